// File: rtl/demux12.sv
// demux12: routes each in_data byte to channel A or B (sinal) through a DEPTH-entry FIFO per channel.
// Latency 1 cycle, no bypass; in_ready drops when the selected FIFO is full. `DEMUX12_COUNT_EN` enables push counters.

module demux12_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop_req,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    // Circular buffer: head is shown combinationally from storage, 0 when empty.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;

    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = pop_req && valid;
    assign dout  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is masked by count until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

module demux12 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sinal,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             a_valid,
    output logic             b_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b
);
    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;

    // A full channel refuses even if it is popped this same cycle.
    assign in_ready = sinal ? !full_b : !full_a;
    assign push_a   = in_valid && in_ready && !sinal;
    assign push_b   = in_valid && in_ready &&  sinal;

    demux12_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_a),
        .din     (in_data),
        .pop_req (a_ready),
        .dout    (out_a),
        .valid   (a_valid),
        .full    (full_a)
    );

    demux12_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_b),
        .din     (in_data),
        .pop_req (b_ready),
        .dout    (out_b),
        .valid   (b_valid),
        .full    (full_b)
    );

`ifdef DEMUX12_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (push_a) cnt_a <= cnt_a + 8'd1;
            if (push_b) cnt_b <= cnt_b + 8'd1;
        end
    end
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif
endmodule

// File: tb/tb_demux12.sv
// Bench for demux12: directed vector table, hand sequences for wrap/reset/counter, random run against a queue model.
module tb_demux12;
    localparam int DEPTH = 2;
`ifdef DEMUX12_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       sinal = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_a, out_b;
    logic       a_valid, b_valid;
    logic       a_ready = 1'b0;
    logic       b_ready = 1'b0;
    logic [7:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int m_cnt_a = 0;
    int m_cnt_b = 0;

    demux12 #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .sinal    (sinal),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .a_ready  (a_ready),
        .b_ready  (b_ready),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic       sel;
        logic       vld;
        logic       ar;
        logic       br;
        logic       e_rdy;
        logic       e_av;
        logic [7:0] e_a;
        logic       e_bv;
        logic [7:0] e_b;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        sinal    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_rdy_a", in_ready, 1);
        sinal = 1'b1;
        #1;
        chk("rst_rdy_b", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock cycle checked against the queue model.
    task automatic cycle(input logic [7:0] d, input logic sel, input logic vld,
                         input logic ar, input logic br);
        bit exp_rdy, acc, pa, pb;
        in_data  = d;
        sinal    = sel;
        in_valid = vld;
        a_ready  = ar;
        b_ready  = br;
        #1;
        exp_rdy = sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        chk("in_ready", in_ready, exp_rdy);
        acc = vld && exp_rdy;
        pa  = ar && (qa.size() > 0);
        pb  = br && (qb.size() > 0);
        @(posedge clk);
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (acc && !sel) begin qa.push_back(d); m_cnt_a = (m_cnt_a + 1) % 256; end
        if (acc &&  sel) begin qb.push_back(d); m_cnt_b = (m_cnt_b + 1) % 256; end
        #1;
        chk("a_valid", a_valid, qa.size() > 0);
        chk("b_valid", b_valid, qb.size() > 0);
        chk("out_a", out_a, (qa.size() > 0) ? qa[0] : 8'h00);
        chk("out_b", out_b, (qb.size() > 0) ? qb[0] : 8'h00);
        chk("cnt_a", cnt_a, CNT_EN ? m_cnt_a : 0);
        chk("cnt_b", cnt_b, CNT_EN ? m_cnt_b : 0);
    endtask

    task automatic apply_vec(input vec_t v);
        in_data  = v.din;
        sinal    = v.sel;
        in_valid = v.vld;
        a_ready  = v.ar;
        b_ready  = v.br;
        #1;
        chk("vec_in_ready", in_ready, v.e_rdy);
        @(posedge clk);
        #1;
        chk("vec_a_valid", a_valid, v.e_av);
        chk("vec_out_a", out_a, v.e_a);
        chk("vec_b_valid", b_valid, v.e_bv);
        chk("vec_out_b", out_b, v.e_b);
    endtask

    initial begin
        logic [7:0] got[$];

        //            din    sel vld ar br  rdy av  a      bv  b
        vecs[0] = '{8'h2D, 0, 1, 0, 0, 1, 1, 8'h2D, 0, 8'h00}; // first push right after reset
        vecs[1] = '{8'hA5, 1, 1, 0, 0, 1, 1, 8'h2D, 1, 8'hA5};
        vecs[2] = '{8'h4E, 1, 1, 0, 0, 1, 1, 8'h2D, 1, 8'hA5}; // B now full
        vecs[3] = '{8'hC3, 1, 1, 0, 0, 0, 1, 8'h2D, 1, 8'hA5}; // refused
        vecs[4] = '{8'hB9, 0, 1, 0, 0, 1, 1, 8'h2D, 1, 8'hA5}; // A proceeds while B full
        vecs[5] = '{8'h77, 1, 1, 0, 1, 0, 1, 8'h2D, 1, 8'h4E}; // no push-on-pop when full
        vecs[6] = '{8'h00, 0, 0, 1, 1, 0, 1, 8'hB9, 0, 8'h00};
        vecs[7] = '{8'h11, 1, 1, 1, 0, 1, 0, 8'h00, 1, 8'h11};
        vecs[8] = '{8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 1, 8'h11}; // a_ready on empty A ignored

        do_reset();
        for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

        // Streaming through A with wrap-around.
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            cycle(8'(i), 1'b0, 1'b1, 1'b1, 1'b0);
            if (a_valid) got.push_back(out_a);
        end
        cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        if (a_valid) got.push_back(out_a);
        chk("stream_len", got.size(), 7);
        for (int i = 0; i < got.size() && i < 7; i++) chk("stream_order", got[i], i + 1);

        // Asynchronous reset mid-cycle with two bytes buffered.
        cycle(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(8'h6B, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_a_valid", a_valid, 0);
        chk("arst_out_a", out_a, 0);
        chk("arst_cnt_a", cnt_a, 0);
        chk("arst_in_ready", in_ready, 1);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("arst_no_old", a_valid, 0);

        // Counter wrap: 257 pushes into A.
        do_reset();
        for (int i = 0; i < 257; i++) cycle(8'(i), 1'b0, 1'b1, 1'b1, 1'b0);
        chk("cnt257_a", cnt_a, CNT_EN ? 1 : 0);
        chk("cnt257_b", cnt_b, 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 500; i++)
            cycle(8'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7),
                  1'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
